// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, through a single
// full-subtractor cell with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_zero;

  logic w_load;
  logic w_shift;
  logic w_finish;
  logic w_last;
  logic w_d;
  logic w_bor_next;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs.
  assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_bor;
  assign w_bor_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_bor);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: default assignment first, so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)  w_next = S_SHIFT;
      S_SHIFT:  if (w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == S_IDLE) && start;
    w_shift  = (r_state == S_SHIFT);
    w_finish = (r_state == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_a_sr  <= a;
        r_b_sr  <= b;
        r_r_sr  <= '0;
        r_bor   <= 1'b0;
        r_cnt   <= '0;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
        r_busy  <= 1'b1;
      end
      if (w_shift) begin
        r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_r_sr <= {w_d, r_r_sr[WIDTH-1:1]};
        r_bor  <= w_bor_next;
        r_cnt  <= r_cnt + CW'(1);
      end
      // Result flags come from the latched operand signs, since the shift registers are drained by now.
      if (w_finish) begin
        r_diff   <= r_r_sr;
        r_borrow <= r_bor;
        r_ovf    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_r_sr[WIDTH-1]);
        r_zero   <= (r_r_sr == '0);
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;
  assign zero       = r_zero;

endmodule
